// File: rtl/mem_arb_pkg.sv
// Shared encodings and helpers for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] OWN_I = 2'b01;
  localparam logic [1:0] OWN_D = 2'b10;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Two-bit bank index starting at bit lsb of a word address.
  function automatic logic [1:0] bank_of(input logic [31:0] addr, input int unsigned lsb);
    logic [31:0] sh;
    sh = addr >> lsb;
    return sh[1:0];
  endfunction

endpackage

// File: rtl/arb_return_pipe.sv
// Tracks in-flight reads so returning data is steered to the requester that issued it.
module arb_return_pipe #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic owner_in,
  output logic valid,
  output logic owner
);

  logic [MEM_LAT-1:0] vld_q;
  logic [MEM_LAT-1:0] own_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q[0] <= issue;
      own_q[0] <= owner_in;
      for (int k = 1; k < MEM_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        own_q[k] <= own_q[k-1];
      end
    end
  end

  assign valid = vld_q[MEM_LAT-1];
  assign owner = own_q[MEM_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Grants the banked main memory to the I-cache or D-cache controller for a whole
// line transaction and routes read data back to whoever issued the read.
//
// state | meaning
// IDLE  | nobody owns memory; no accesses issued
// OWN_I | I-cache controller owns memory
// OWN_D | D-cache controller owns memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MEM_LAT  = 2,
  parameter int BANK_LSB = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              req_d,
  input  logic              rd_d,
  input  logic              wr_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] wdata_d,
  output logic              gnt_i,
  output logic              stall_i,
  output logic              rvalid_i,
  output logic [DATA_W-1:0] rdata_i,
  output logic              err_i,
  output logic              gnt_d,
  output logic              stall_d,
  output logic              rvalid_d,
  output logic [DATA_W-1:0] rdata_d,
  output logic              err_d,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [3:0]        mem_busy,
  input  logic              mem_stall,
  input  logic              mem_err
);

  logic [1:0] state_q, state_d;
  logic       last_gnt_q, last_gnt_d;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (req_i && (!req_d || last_gnt_q == REQ_D)) begin
          state_d    = OWN_I;
          last_gnt_d = REQ_I;
        end else if (req_d) begin
          state_d    = OWN_D;
          last_gnt_d = REQ_D;
        end
      end
      OWN_I: begin
        if (!req_i) begin
          if (req_d) begin
            state_d    = OWN_D;
            last_gnt_d = REQ_D;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OWN_D: begin
        if (!req_d) begin
          if (req_i) begin
            state_d    = OWN_I;
            last_gnt_d = REQ_I;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= REQ_D;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  logic              own_i, own_d;
  logic              o_req, o_rd, o_wr;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_wdata;
  logic [1:0]        o_bank;
  logic              active, conflict, issue;

  assign own_i = (state_q == OWN_I);
  assign own_d = (state_q == OWN_D);

  // Owner's request lines; meaningless in IDLE since active is then low.
  assign o_req   = own_d ? req_d   : req_i;
  assign o_rd    = own_d ? rd_d    : rd_i;
  assign o_wr    = own_d ? wr_d    : wr_i;
  assign o_addr  = own_d ? addr_d  : addr_i;
  assign o_wdata = own_d ? wdata_d : wdata_i;
  assign o_bank  = bank_of(32'(o_addr), BANK_LSB);

  assign active   = (own_i | own_d) & o_req;
  assign conflict = active & o_rd & o_wr;
  assign issue    = active & (o_rd ^ o_wr) & !mem_busy[o_bank] & !mem_stall;

  assign mem_rd    = issue & o_rd;
  assign mem_wr    = issue & o_wr;
  assign mem_addr  = issue ? o_addr : '0;
  assign mem_wdata = issue ? o_wdata : '0;

  assign gnt_i = own_i;
  assign gnt_d = own_d;

  // Rd/wr with req low is ignored by the owner, so no stall is reported for it.
  assign stall_i = !rst & (own_i ? (active & (rd_i | wr_i) & !issue) : (rd_i | wr_i));
  assign stall_d = !rst & (own_d ? (active & (rd_d | wr_d) & !issue) : (rd_d | wr_d));

  // Only the owner can issue, so a memory error always belongs to the owner.
  assign err_i = !rst & own_i & (conflict | mem_err);
  assign err_d = !rst & own_d & (conflict | mem_err);

  logic ret_valid, ret_owner;

  arb_return_pipe #(
    .MEM_LAT(MEM_LAT)
  ) u_return_pipe (
    .clk      (clk),
    .rst      (rst),
    .issue    (mem_rd),
    .owner_in (own_d),
    .valid    (ret_valid),
    .owner    (ret_owner)
  );

  assign rvalid_i = ret_valid & (ret_owner == REQ_I);
  assign rvalid_d = ret_valid & (ret_owner == REQ_D);
  assign rdata_i  = rvalid_i ? mem_rdata : '0;
  assign rdata_d  = rvalid_d ? mem_rdata : '0;

endmodule
